regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_arb_pkg.sv | 19 +
 rtl/regfile_write_arbiter_if.sv | 38 +++
 rtl/rf_req_slot.sv | 56 +++++
 rtl/regfile_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared defaults, requester id and slot record for the write arbiter
package regfile_arb_pkg;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester handshakes and register-file write port bundle
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) ();

  logic                req0_valid;
  logic                req0_ready;
  logic [ADDR_W-1:0]   req0_addr;
  logic [DATA_W-1:0]   req0_data;
  logic                req1_valid;
  logic                req1_ready;
  logic [ADDR_W-1:0]   req1_addr;
  logic [DATA_W-1:0]   req1_data;
  logic                regWrite;
  logic [ADDR_W-1:0]   writeReg;
  logic [DATA_W-1:0]   writeData;
  logic [NUM_REGS-1:0] busy_mask;
  logic                addr_err;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  regWrite, writeReg, writeData, busy_mask, addr_err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output regWrite, writeReg, writeData, busy_mask, addr_err
  );

endinterface

// File: rtl/rf_req_slot.sv
// rtl/rf_req_slot.sv - one-entry holding slot for a single write requester
module rf_req_slot
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              grant_i,
  output logic              in_ready_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A granted entry leaves on this edge, so the slot may be refilled on the same edge.
  assign in_ready_o = ~valid_q | grant_i;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      addr_d  = in_addr_i;
      data_d  = in_data_i;
    end else if (grant_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write arbiter with registered write port
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority to req0.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                    clock_in,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  logic              s0_ready, s1_ready;
  logic              s0_valid, s1_valid;
  logic [ADDR_W-1:0] s0_addr, s1_addr;
  logic [DATA_W-1:0] s0_data, s1_data;
  logic              grant0, grant1;
  logic              prefer0;

  rf_req_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk_i      (clock_in),
    .rst_i      (rst),
    .in_valid_i (bus.req0_valid),
    .in_addr_i  (bus.req0_addr),
    .in_data_i  (bus.req0_data),
    .grant_i    (grant0),
    .in_ready_o (s0_ready),
    .valid_o    (s0_valid),
    .addr_o     (s0_addr),
    .data_o     (s0_data)
  );

  rf_req_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk_i      (clock_in),
    .rst_i      (rst),
    .in_valid_i (bus.req1_valid),
    .in_addr_i  (bus.req1_addr),
    .in_data_i  (bus.req1_data),
    .grant_i    (grant1),
    .in_ready_o (s1_ready),
    .valid_o    (s1_valid),
    .addr_o     (s1_addr),
    .data_o     (s1_data)
  );

  assign bus.req0_ready = s0_ready;
  assign bus.req1_ready = s1_ready;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t last_grant_q, last_grant_d;

  assign prefer0 = (last_grant_q == REQ1);

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0) begin
      last_grant_d = REQ0;
    end else if (grant1) begin
      last_grant_d = REQ1;
    end
  end

  // Reset to "req1 granted last" so req0 wins the first contest.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      last_grant_q <= REQ1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign prefer0 = 1'b1;
`endif

  assign grant0 = s0_valid & (~s1_valid | prefer0);
  assign grant1 = s1_valid & ~grant0;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_in_range;

  always_comb begin
    sel_addr     = grant1 ? s1_addr : s0_addr;
    sel_data     = grant1 ? s1_data : s0_data;
    sel_in_range = (32'(sel_addr) < NUM_REGS);
    reg_write_d  = 1'b0;
    addr_err_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    // Out-of-range entries are dropped; the write port keeps its previous address/data.
    if (grant0 || grant1) begin
      if (sel_in_range) begin
        reg_write_d  = 1'b1;
        write_reg_d  = sel_addr;
        write_data_d = sel_data;
      end else begin
        addr_err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.regWrite  = reg_write_q;
  assign bus.writeReg  = write_reg_q;
  assign bus.writeData = write_data_q;
  assign bus.addr_err  = addr_err_q;

  logic [NUM_REGS-1:0] busy_mask_c;

  always_comb begin
    busy_mask_c = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if ((s0_valid && (32'(s0_addr) == k)) ||
          (s1_valid && (32'(s1_addr) == k)) ||
          (reg_write_q && (32'(write_reg_q) == k))) begin
        busy_mask_c[k] = 1'b1;
      end
    end
  end

  assign bus.busy_mask = busy_mask_c;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench: directed table, corner sequences, random vs reference model
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int NR = 8;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clock_in = 1'b0;
  logic rst      = 1'b1;
  always #5 clock_in = ~clock_in;

  regfile_write_arbiter_if #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_write_arbiter #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock_in (clock_in),
    .rst      (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: per-requester held entry, registered write port, favoured requester
  slot_t          m_slot [2];
  logic           m_we;
  logic [AW-1:0]  m_wa;
  logic [DW-1:0]  m_wd;
  logic           m_err;
  int             m_last;

  logic           in_r;
  logic           in_v [2];
  logic [AW-1:0]  in_a [2];
  logic [DW-1:0]  in_d [2];

  logic [DW-1:0]  rf_dut [NR];
  int             wr_addr [$];
  logic [DW-1:0]  wr_data [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int m_winner();
    if (m_slot[0].valid && m_slot[1].valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (m_slot[0].valid) return 0;
    if (m_slot[1].valid) return 1;
    return -1;
  endfunction

  function automatic logic m_ready(input int n);
    return !m_slot[n].valid || (m_winner() == n);
  endfunction

  function automatic logic [NR-1:0] m_busy();
    logic [NR-1:0] b = '0;
    for (int n = 0; n < 2; n++)
      if (m_slot[n].valid && int'(m_slot[n].addr) < NR) b[m_slot[n].addr] = 1'b1;
    if (m_we) b[m_wa] = 1'b1;
    return b;
  endfunction

  task automatic model_edge();
    int   w;
    logic rdy [2];
    w      = m_winner();
    rdy[0] = m_ready(0);
    rdy[1] = m_ready(1);
    if (in_r) begin
      m_slot[0] = '0; m_slot[1] = '0;
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_err = 1'b0; m_last = 1;
    end else begin
      m_we  = 1'b0;
      m_err = 1'b0;
      if (w >= 0) begin
        if (int'(m_slot[w].addr) < NR) begin
          m_we = 1'b1; m_wa = m_slot[w].addr; m_wd = m_slot[w].data;
        end else begin
          m_err = 1'b1;
        end
        m_last = w;
      end
      for (int n = 0; n < 2; n++) begin
        if (in_v[n] && rdy[n]) m_slot[n] = '{1'b1, in_a[n], in_d[n]};
        else if (w == n)       m_slot[n].valid = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    in_r = r; in_v[0] = v0; in_a[0] = a0; in_d[0] = d0; in_v[1] = v1; in_a[1] = a1; in_d[1] = d1;
    rst = r;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick();
    #1;
    chk("req0_ready", bus.req0_ready, m_ready(0));
    chk("req1_ready", bus.req1_ready, m_ready(1));
    @(posedge clock_in);
    model_edge();
    @(negedge clock_in);
    if (bus.regWrite === 1'b1) begin
      wr_addr.push_back(int'(bus.writeReg));
      wr_data.push_back(bus.writeData);
      if (int'(bus.writeReg) < NR) rf_dut[bus.writeReg] = bus.writeData;
    end
    chk("regWrite",  bus.regWrite,  m_we);
    chk("writeReg",  bus.writeReg,  m_wa);
    chk("writeData", bus.writeData, m_wd);
    chk("addr_err",  bus.addr_err,  m_err);
    chk("busy_mask", bus.busy_mask, m_busy());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      tick();
    end
  endtask

  typedef struct {
    logic          r;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic          e_err;
    logic [NR-1:0] e_busy;
    logic          e_rdy0;
    logic          e_rdy1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         1'b0, 8'h00, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 5'd3, 32'hA5A5_0001, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         1'b0, 8'h08, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'hA5A5_0001, 1'b0, 8'h08, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 32'hA5A5_0001, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 32'hDEAD, 1'b0, 5'd3, 32'hA5A5_0001, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 32'hA5A5_0001, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 32'hA5A5_0001, 1'b0, 8'h00, 1'b1, 1'b1};

    for (int k = 0; k < NR; k++) rf_dut[k] = '0;
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    @(posedge clock_in);
    model_edge();
    @(negedge clock_in);

    // Directed table: single write latency, then an out-of-range drop
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].r, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      tick();
      chk($sformatf("vec%0d_regWrite", i),  bus.regWrite,   vecs[i].e_we);
      chk($sformatf("vec%0d_writeReg", i),  bus.writeReg,   vecs[i].e_wa);
      chk($sformatf("vec%0d_writeData", i), bus.writeData,  vecs[i].e_wd);
      chk($sformatf("vec%0d_addr_err", i),  bus.addr_err,   vecs[i].e_err);
      chk($sformatf("vec%0d_busy", i),      bus.busy_mask,  vecs[i].e_busy);
      chk($sformatf("vec%0d_rdy0", i),      bus.req0_ready, vecs[i].e_rdy0);
      chk($sformatf("vec%0d_rdy1", i),      bus.req1_ready, vecs[i].e_rdy1);
    end

    // Both requesters streaming to distinct registers
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    wr_addr.delete(); wr_data.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 5'd1, 32'(i), 1'b1, 5'd2, 32'(100 + i));
      tick();
    end
    chk("stream_count", wr_addr.size(), 5);
    foreach (wr_addr[i]) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk("stream_rr_order", wr_addr[i], (i % 2 == 0) ? 1 : 2);
`else
      chk("stream_fixed_order", wr_addr[i], 1);
`endif
    end
`ifndef ARB_ROUND_ROBIN_EN
    chk("stream_req1_blocked", bus.req1_ready, 1'b0);
`endif

    // Reset with both slots occupied and a coincident handshake
    drive(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    tick();
    wr_addr.delete(); wr_data.delete();
    idle(3);
    chk("rst_no_write", wr_addr.size(), 0);
    chk("rst_busy",     bus.busy_mask, 8'h00);
    chk("rst_rdy0",     bus.req0_ready, 1'b1);
    chk("rst_rdy1",     bus.req1_ready, 1'b1);

    // Same-register collision: grant order decides the surviving value
    drive(1'b0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
    tick();
    idle(4);
    chk("same_reg_count", wr_data.size(), 2);
    if (wr_data.size() == 2) begin
      chk("same_reg_first",  wr_data[0], 32'h11);
      chk("same_reg_second", wr_data[1], 32'h22);
    end
    chk("same_reg_final", rf_dut[5], 32'h22);

    // Randomized traffic including out-of-range addresses and sporadic resets
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 11)), $urandom(),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 11)), $urandom());
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
